vga_fb_apb: RTL

//  APB-slave framebuffer and pixel source feeding the VGA timing/output stage.
//  CPU writes/reads 24-bit RGB pixels (one per 32-bit word) through APB.
//  The timing stage requests pixels by (x,y); the block returns {r,g,b} one cycle later.

---
 rtl/vga_fb_apb.sv | 159 +++++++++++++++
 1 files changed

// File: rtl/vga_fb_apb.sv
// APB-slave framebuffer with a one-cycle pixel read port for the VGA timing stage.
// Holds one 24-bit RGB pixel per word plus CTRL, BGCOLOR and a STATUS frame counter.
module vga_fb_apb #(
  parameter int H_ACT = 640,
  parameter int V_ACT = 480,
  parameter int FB_AW = 19
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] in_paddr,
  input  logic        in_psel,
  input  logic        in_penable,
  input  logic [2:0]  in_pprot,
  input  logic        in_pwrite,
  input  logic [31:0] in_pwdata,
  input  logic [3:0]  in_pstrb,
  output logic        in_pready,
  output logic [31:0] in_prdata,
  output logic        in_pslverr,
  input  logic        frame_start,
  input  logic        pix_req,
  input  logic [9:0]  pix_x,
  input  logic [9:0]  pix_y,
  output logic [23:0] pix_rgb,
  output logic        pix_valid
);

  localparam int FB_WORDS = H_ACT * V_ACT;
  localparam logic [FB_AW:0] FB_WORDS_W = FB_WORDS[FB_AW:0];
  localparam logic [FB_AW:0] H_ACT_W = H_ACT[FB_AW:0];
  localparam logic [10:0] H_LIM = H_ACT[10:0];
  localparam logic [10:0] V_LIM = V_ACT[10:0];

  typedef enum logic {IDLE, RD_WAIT} apb_state_t;

  // APB handshake: a transfer completes in the cycle where psel, penable and pready
  // are all high; prdata/pslverr are only meaningful then and read as 0 otherwise.
  apb_state_t state;

  logic [23:0] mem [0:FB_WORDS-1];
  logic [23:0] ram_a;
  logic [23:0] ram_b;

  logic        en;
  logic [23:0] bgcolor;
  logic [15:0] frame_cnt;
  logic        use_fb;
  logic [23:0] bg_q;

  logic             access;
  logic             is_reg;
  logic [FB_AW-1:0] fb_idx;
  logic             fb_err;
  logic             fb_rd;
  logic             fb_wr;
  logic             reg_wr;
  logic [31:0]      reg_rdata;
  logic [FB_AW:0]   pix_idx;
  logic             pix_in_range;
  logic             pix_in_fb;
  logic             unused;

  assign unused = ^{in_paddr[31:22], in_paddr[1:0], in_pprot, in_pstrb[3]};

  // Gating with reset makes an access abort immediately when reset drops mid-transfer.
  assign access = reset & in_psel & in_penable;
  assign is_reg = in_paddr[21];
  assign fb_idx = in_paddr[FB_AW+1:2];
  assign fb_err = !is_reg && ({1'b0, fb_idx} >= FB_WORDS_W);
  assign fb_rd  = access && (state == IDLE) && !is_reg && !in_pwrite && !fb_err;
  assign fb_wr  = access && (state == IDLE) && !is_reg && in_pwrite && !fb_err;
  assign reg_wr = access && (state == IDLE) && is_reg && in_pwrite;

  always_comb begin
    reg_rdata = 32'h0;
    case (in_paddr[3:2])
      2'd0:    reg_rdata = {31'h0, en};
      2'd1:    reg_rdata = {8'h0, bgcolor};
      2'd2:    reg_rdata = {16'h0, frame_cnt};
      default: reg_rdata = 32'h0;
    endcase
  end

  always_comb begin
    in_pready  = 1'b0;
    in_prdata  = 32'h0;
    in_pslverr = 1'b0;
    case (state)
      IDLE: begin
        if (access && !fb_rd) begin
          in_pready  = 1'b1;
          in_pslverr = fb_err;
          if (is_reg && !in_pwrite) in_prdata = reg_rdata;
        end
      end
      RD_WAIT: begin
        if (reset && in_psel) begin
          in_pready = 1'b1;
          in_prdata = {8'h0, ram_a};
        end
      end
      default: ;
    endcase
  end

  // Index math at FB_AW+1 bits so the largest 10-bit x/y cannot wrap into range.
  assign pix_idx      = {{(FB_AW-9){1'b0}}, pix_y} * H_ACT_W + {{(FB_AW-9){1'b0}}, pix_x};
  assign pix_in_range = ({1'b0, pix_x} < H_LIM) && ({1'b0, pix_y} < V_LIM);
  assign pix_in_fb    = en && pix_in_range;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      en        <= 1'b0;
      bgcolor   <= 24'h0;
      frame_cnt <= 16'h0;
      use_fb    <= 1'b0;
      bg_q      <= 24'h0;
      pix_valid <= 1'b0;
    end else begin
      case (state)
        IDLE:    if (fb_rd) state <= RD_WAIT;
        RD_WAIT: state <= IDLE;
        default: state <= IDLE;
      endcase
      if (reg_wr) begin
        case (in_paddr[3:2])
          2'd0: if (in_pstrb[0]) en <= in_pwdata[0];
          2'd1: begin
            if (in_pstrb[0]) bgcolor[7:0]   <= in_pwdata[7:0];
            if (in_pstrb[1]) bgcolor[15:8]  <= in_pwdata[15:8];
            if (in_pstrb[2]) bgcolor[23:16] <= in_pwdata[23:16];
          end
          default: ;
        endcase
      end
      if (frame_start) frame_cnt <= frame_cnt + 16'h1;
      pix_valid <= pix_req;
      if (pix_req) begin
        use_fb <= pix_in_fb;
        bg_q   <= bgcolor;
      end
    end
  end

  // Both ports use non-blocking access, so a same-cycle collision reads the old word.
  always_ff @(posedge clock) begin
    if (fb_wr) begin
      if (in_pstrb[0]) mem[fb_idx][7:0]   <= in_pwdata[7:0];
      if (in_pstrb[1]) mem[fb_idx][15:8]  <= in_pwdata[15:8];
      if (in_pstrb[2]) mem[fb_idx][23:16] <= in_pwdata[23:16];
    end
    if (fb_rd) ram_a <= mem[fb_idx];
    if (pix_req && pix_in_fb) ram_b <= mem[pix_idx[FB_AW-1:0]];
  end

  assign pix_rgb = use_fb ? ram_b : bg_q;

endmodule
